// File: rtl/ppu_pkg.sv
// Shared constants and types for the PPU-side CPU bus blocks.
// Holds the sprite DMA state encoding and the register addresses it uses.
package ppu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_e;

  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

  localparam int         DMA_LEN      = 256;
  localparam logic [7:0] DMA_LAST_CNT = 8'(DMA_LEN - 1);

endpackage

// File: rtl/ppu_spr_dma.sv
// Sprite DMA initiator: a CPU write to $4014 halts the CPU and copies one
// 256-byte page into sprite RAM as a stream of ordinary CPU-bus writes to $2004.
module ppu_spr_dma
  import ppu_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cpu_ce_in,
  input  logic [15:0] cpu_addr_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  cpu_d_in,
  input  logic [7:0]  bus_d_in,
  output logic        active_out,
  output logic        cpu_rdy_out,
  output logic [15:0] addr_out,
  output logic        r_nw_out,
  output logic [7:0]  d_out
);

  dma_state_e  state_q, state_d;
  logic        q_odd_q, q_odd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  data_q, data_d;

  logic        active_q, active_d;
  logic        cpu_rdy_q, cpu_rdy_d;
  logic [15:0] addr_q, addr_d;
  logic        r_nw_q, r_nw_d;
  logic [7:0]  d_q, d_d;

  // Next-state logic; nothing advances between cpu_ce_in pulses.
  always_comb begin
    state_d = state_q;
    q_odd_d = q_odd_q;
    cnt_d   = cnt_q;
    page_d  = page_q;
    data_d  = data_q;

    if (cpu_ce_in) begin
      q_odd_d = ~q_odd_q;
      case (state_q)
        ST_IDLE: begin
          if (cpu_addr_in == OAMDMA_ADDR && !cpu_r_nw_in) begin
            page_d  = cpu_d_in;
            cnt_d   = 8'h00;
            state_d = ST_HALT;
          end
        end
        // q_odd_q is the parity of the HALT cycle ending now; inserting ALIGN
        // after an even HALT makes every READ land on an even-parity cycle.
        ST_HALT:  state_d = q_odd_q ? ST_READ : ST_ALIGN;
        ST_ALIGN: state_d = ST_READ;
        ST_READ: begin
          data_d  = bus_d_in;
          state_d = ST_WRITE;
        end
        ST_WRITE: begin
          if (cnt_q == DMA_LAST_CNT) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = ST_READ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered and
  // describe the CPU cycle that begins after the ce edge.
  always_comb begin
    active_d  = (state_d != ST_IDLE);
    cpu_rdy_d = (state_d == ST_IDLE);
    addr_d    = 16'h0000;
    r_nw_d    = 1'b1;
    d_d       = 8'h00;
    case (state_d)
      ST_READ: addr_d = {page_d, cnt_d};
      ST_WRITE: begin
        addr_d = OAMDATA_ADDR;
        r_nw_d = 1'b0;
        d_d    = data_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      q_odd_q   <= 1'b0;
      cnt_q     <= 8'h00;
      page_q    <= 8'h00;
      data_q    <= 8'h00;
      active_q  <= 1'b0;
      cpu_rdy_q <= 1'b1;
      addr_q    <= 16'h0000;
      r_nw_q    <= 1'b1;
      d_q       <= 8'h00;
    end else begin
      state_q   <= state_d;
      q_odd_q   <= q_odd_d;
      cnt_q     <= cnt_d;
      page_q    <= page_d;
      data_q    <= data_d;
      active_q  <= active_d;
      cpu_rdy_q <= cpu_rdy_d;
      addr_q    <= addr_d;
      r_nw_q    <= r_nw_d;
      d_q       <= d_d;
    end
  end

  assign active_out  = active_q;
  assign cpu_rdy_out = cpu_rdy_q;
  assign addr_out    = addr_q;
  assign r_nw_out    = r_nw_q;
  assign d_out       = d_q;

endmodule

// File: tb/tb_ppu_spr_dma.sv
// Directed bench for ppu_spr_dma: drives CPU cycles with a variable number of
// idle clocks between ce pulses and checks each transfer against a cycle model.
module tb_ppu_spr_dma;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        cpu_ce_in = 1'b0;
  logic [15:0] cpu_addr_in = 16'h0000;
  logic        cpu_r_nw_in = 1'b1;
  logic [7:0]  cpu_d_in = 8'h00;
  logic [7:0]  bus_d_in = 8'h00;
  logic        active_out;
  logic        cpu_rdy_out;
  logic [15:0] addr_out;
  logic        r_nw_out;
  logic [7:0]  d_out;

  int tests = 0;
  int fails = 0;
  int ce_cnt = 0;

  ppu_spr_dma dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .cpu_ce_in   (cpu_ce_in),
    .cpu_addr_in (cpu_addr_in),
    .cpu_r_nw_in (cpu_r_nw_in),
    .cpu_d_in    (cpu_d_in),
    .bus_d_in    (bus_d_in),
    .active_out  (active_out),
    .cpu_rdy_out (cpu_rdy_out),
    .addr_out    (addr_out),
    .r_nw_out    (r_nw_out),
    .d_out       (d_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU cycle: drive the core's bus, idle a few clocks, then pulse ce.
  // Memory model: byte at $XXii reads back ii ^ 5A.
  task automatic cpu_cycle(input logic [15:0] a, input logic rnw, input logic [7:0] d);
    int gap;
    gap = $urandom_range(0, 2);
    cpu_addr_in = a;
    cpu_r_nw_in = rnw;
    cpu_d_in    = d;
    repeat (gap) begin
      @(posedge clk_in);
      #1;
    end
    bus_d_in  = addr_out[7:0] ^ 8'h5A;
    cpu_ce_in = 1'b1;
    @(posedge clk_in);
    #1;
    cpu_ce_in   = 1'b0;
    cpu_addr_in = 16'h0000;
    cpu_r_nw_in = 1'b1;
    cpu_d_in    = 8'h00;
    ce_cnt++;
  endtask

  // Steps through a transfer already triggered, comparing every halted cycle
  // against HALT, [ALIGN], then READ {page,i} / WRITE $2004 (i^5A) pairs.
  task automatic run_dma(input logic [7:0] page, input bit odd, input int inject,
                         output int n, output int bad, output logic [15:0] first_rd,
                         output logic [15:0] last_rd, output int wr);
    int off;
    int k;
    logic [15:0] ea;
    logic        er;
    logic [7:0]  ed;
    logic [7:0]  idx;
    n = 0; bad = 0; wr = 0;
    first_rd = 16'hxxxx; last_rd = 16'hxxxx;
    off = odd ? 2 : 1;
    while (cpu_rdy_out === 1'b0 && n < 600) begin
      ea = 16'h0000; er = 1'b1; ed = 8'h00;
      if (n >= off) begin
        k   = n - off;
        idx = 8'(k / 2);
        if (k >= 512) begin
          ea = 16'hDEAD;
        end else if (k % 2 == 0) begin
          ea = {page, idx};
          if (k == 0) first_rd = addr_out;
          last_rd = addr_out;
        end else begin
          ea = 16'h2004; er = 1'b0; ed = idx ^ 8'h5A;
        end
      end
      if (active_out !== 1'b1 || addr_out !== ea || r_nw_out !== er || d_out !== ed) bad++;
      if (r_nw_out === 1'b0) wr++;
      if (n == inject) cpu_cycle(16'h4014, 1'b0, 8'h77);
      else             cpu_cycle(16'h0000, 1'b1, 8'h00);
      n++;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_active"}, 32'(active_out), 32'h0);
    chk({tag, "_rdy"},    32'(cpu_rdy_out), 32'h1);
    chk({tag, "_addr"},   32'(addr_out), 32'h0000);
    chk({tag, "_rnw"},    32'(r_nw_out), 32'h1);
    chk({tag, "_dout"},   32'(d_out), 32'h00);
  endtask

  initial begin
    int n, bad, wr, found;
    logic [15:0] frd, lrd;

    // Reset for three clocks.
    repeat (3) @(posedge clk_in);
    #1;
    chk_idle("reset");
    rst_in = 1'b0;
    ce_cnt = 0;

    // Even-parity trigger, page 02.
    cpu_cycle(16'h4014, 1'b0, 8'h02);
    chk("even_trig_rdy", 32'(cpu_rdy_out), 32'h0);
    chk("even_trig_active", 32'(active_out), 32'h1);
    run_dma(8'h02, 1'b0, -1, n, bad, frd, lrd, wr);
    chk("even_len", 32'(n), 32'd513);
    chk("even_seq", 32'(bad), 32'd0);
    chk("even_first_rd", 32'(frd), 32'h0200);
    chk("even_last_rd", 32'(lrd), 32'h02FF);
    chk("even_writes", 32'(wr), 32'd256);
    chk_idle("even_done");

    // Non-triggers in IDLE: $4014 read, $4015 write, $4014 write without ce.
    cpu_cycle(16'h4014, 1'b1, 8'h55);
    chk("rd4014_rdy", 32'(cpu_rdy_out), 32'h1);
    cpu_cycle(16'h4015, 1'b0, 8'h55);
    chk("wr4015_rdy", 32'(cpu_rdy_out), 32'h1);
    cpu_addr_in = 16'h4014; cpu_r_nw_in = 1'b0; cpu_d_in = 8'h55;
    repeat (3) @(posedge clk_in);
    #1;
    chk("noce_rdy", 32'(cpu_rdy_out), 32'h1);
    chk("noce_active", 32'(active_out), 32'h0);
    cpu_addr_in = 16'h0000; cpu_r_nw_in = 1'b1; cpu_d_in = 8'h00;

    // Odd-parity trigger with a $4014 write injected mid-transfer.
    if (ce_cnt % 2 == 0) cpu_cycle(16'h0000, 1'b1, 8'h00);
    cpu_cycle(16'h4014, 1'b0, 8'h02);
    chk("odd_trig_rdy", 32'(cpu_rdy_out), 32'h0);
    run_dma(8'h02, 1'b1, 10, n, bad, frd, lrd, wr);
    chk("odd_len", 32'(n), 32'd514);
    chk("odd_seq", 32'(bad), 32'd0);
    chk("odd_first_rd", 32'(frd), 32'h0200);
    chk("odd_last_rd", 32'(lrd), 32'h02FF);
    chk("odd_writes", 32'(wr), 32'd256);

    // Page FF: no carry into page 00.
    if (ce_cnt % 2 == 1) cpu_cycle(16'h0000, 1'b1, 8'h00);
    cpu_cycle(16'h4014, 1'b0, 8'hFF);
    run_dma(8'hFF, 1'b0, -1, n, bad, frd, lrd, wr);
    chk("ff_len", 32'(n), 32'd513);
    chk("ff_seq", 32'(bad), 32'd0);
    chk("ff_first_rd", 32'(frd), 32'hFF00);
    chk("ff_last_rd", 32'(lrd), 32'hFFFF);
    chk_idle("ff_done");

    // Reset during the WRITE of byte 40, then restart from page 03.
    cpu_cycle(16'h4014, 1'b0, 8'h02);
    found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      if (r_nw_out === 1'b0 && d_out === (8'h40 ^ 8'h5A)) found = 1;
      else cpu_cycle(16'h0000, 1'b1, 8'h00);
    end
    chk("w40_found", 32'(found), 32'd1);
    chk("w40_addr", 32'(addr_out), 32'h2004);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk_idle("midrst");
    rst_in = 1'b0;
    ce_cnt = 0;
    cpu_cycle(16'h4014, 1'b0, 8'h03);
    run_dma(8'h03, 1'b0, -1, n, bad, frd, lrd, wr);
    chk("restart_len", 32'(n), 32'd513);
    chk("restart_seq", 32'(bad), 32'd0);
    chk("restart_first_rd", 32'(frd), 32'h0300);
    chk("restart_last_rd", 32'(lrd), 32'h03FF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ppu_spr_dma.md
# ppu_spr_dma

Sprite DMA initiator for the CPU-side bus. A CPU write to $4014 triggers it. It halts the CPU and copies 256 bytes from CPU page `$XX00–$XXFF` into sprite RAM. Each byte is issued as an ordinary CPU-bus write to $2004, so the PPU register interface receives one /CS falling edge per byte. The block sits between the CPU core and the CPU bus address decoder, alongside the PPU.

## Interface
Parameters: none.

Clock and reset are fixed: one clock; reset is synchronous and active-high.

- `clk_in`  in  1  system clock (PPU clock domain)
- `rst_in`  in  1  synchronous, active-high reset
- `cpu_ce_in`  in  1  one-clk pulse marking the end of each CPU cycle; all DMA state advances only on this pulse
- `cpu_addr_in`  in  16  CPU core address
- `cpu_r_nw_in`  in  1  CPU core direction (1 = read)
- `cpu_d_in`  in  8  CPU core write data
- `bus_d_in`  in  8  CPU-bus read data, valid when `cpu_ce_in` is high
- `active_out`  out  1  DMA owns the bus; the external mux selects the DMA outputs
- `cpu_rdy_out`  out  1  0 = CPU core halted
- `addr_out`  out  16  DMA bus address
- `r_nw_out`  out  1  DMA bus direction
- `d_out`  out  8  DMA bus write data

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- `q_odd` tracks CPU-cycle parity.
  - It toggles on every `cpu_ce_in`.
  - It holds the parity of the cycle currently ending.
- Trigger condition: IDLE & `cpu_ce_in` & `cpu_addr_in`==16'h4014 & ~`cpu_r_nw_in`.
  - On trigger: latch page = `cpu_d_in`, clear byte counter `cnt`[7:0], go to HALT.
- HALT (dummy cycle, bus outputs idle):
  - If `q_odd`==0 at its end, go to ALIGN.
  - Otherwise go to READ.
  - Net effect: every READ ends on an even-parity cycle.
- ALIGN (dummy cycle): go to READ.
- READ:
  - Drive `addr_out`={page,cnt}, `r_nw_out`=1.
  - At end of cycle, capture `bus_d_in` into the data latch, then go to WRITE.
- WRITE:
  - Drive `addr_out`=16'h2004, `r_nw_out`=0, `d_out`=data latch.
  - At end of cycle: if `cnt`==8'hFF go to IDLE; else increment `cnt` and go to READ.
- Signal states:
  - `active_out`=1 and `cpu_rdy_out`=0 in every state except IDLE.
  - In IDLE and non-WRITE states: `addr_out`=0, `r_nw_out`=1, `d_out`=0, except in READ as above.
- Transfer length: 513 CPU cycles when triggered on an even-parity cycle, 514 when triggered on an odd-parity cycle.
- Address arithmetic:
  - `cnt` is 8-bit; the page never increments.
  - Page $FF reads $FF00–$FFFF, with no carry.
- Boundary conditions:
  - $4014 reads, and writes to any other address, never trigger.
  - $4014 writes while not IDLE are ignored.
  - `cpu_ce_in` absent: all state holds.
  - Reset mid-transfer: IDLE on the next edge, counter cleared, outputs at reset values. The next trigger restarts at byte 0.

## Timing
- All outputs are registered and update on the `clk_in` edge where `cpu_ce_in`=1.
  - They describe the CPU cycle that starts after that edge.
  - They are stable for the whole CPU cycle.
- Reset values:
  - state=IDLE, `q_odd`=0, `cnt`=0, page=0, data latch=0.
  - `active_out`=0, `cpu_rdy_out`=1, `addr_out`=16'h0000, `r_nw_out`=1, `d_out`=8'h00.
- Trigger latency: `cpu_rdy_out` falls at the same ce edge that samples the $4014 write. It rises at the ce edge ending the final WRITE.
- Read latency: `bus_d_in` is sampled at the ce edge ending READ and appears on `d_out` for the immediately following WRITE cycle.
- Write strobes: consecutive $2004 writes are separated by a READ cycle, so the decoder's /CS for the PPU deasserts between them. Each byte produces exactly one falling edge.

## Structure
- Shared package `ppu_pkg` holds:
  - State enumeration (3-bit).
  - `OAMDMA_ADDR`=16'h4014, `OAMDATA_ADDR`=16'h2004.
  - DMA length constant 256.
- Single flat module; no sub-module.
- The bus mux (`active_out` select) lives in the top-level CPU bus fabric, not in this block.

## Test plan
- Reset: hold `rst_in` 3 clks. Outputs must be `active_out`=0, `cpu_rdy_out`=1, `addr_out`=0000, `r_nw_out`=1, `d_out`=00.
- Write $4014=8'h02 on an even-parity cycle, with memory model byte[i]=i^8'h5A:
  - `cpu_rdy_out` must be low for exactly 513 ce pulses.
  - READ addresses must run 0200..02FF.
  - There must be 256 writes to 2004 with data i^5A, in order.
- Same trigger on an odd-parity cycle: exactly 514 ce pulses, with one ALIGN cycle before the first READ.
- Page 8'hFF: last READ address must be FFFF, then a WRITE, then IDLE, with no access to 0000.
- Non-triggers: a $4014 read, a write to $4015, and a write to $4014 while active must not start or restart a transfer (counter and latched page unchanged).
- Assert `rst_in` during the WRITE of byte 8'h40:
  - IDLE on the next clk.
  - A new $4014=8'h03 trigger must read 0300 first.
